ut_led_pattern_gen: RTL and testbench

Parametrised, clocked successor to the board unit-test LED/button block. It synchronises and debounces N_BUT active-low buttons and latches a display mode on each press. It drives N_LED registered LEDs with static or animated patterns (walk, blink) paced by a step timer. It is used as the PLD-load unit-test image on the pico-ice40 probe board.

---
 rtl/ut_pkg.sv | 14 +
 rtl/ut_debounce.sv | 40 ++++
 rtl/ut_led_pattern_gen.sv | 86 ++++++++
 tb/tb_ut_led_pattern_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ut_pkg.sv
// ut_pkg: mode encoding, button-to-mode map and pattern constants for the LED unit-test block.
package ut_pkg;
  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_ALT   = 3'd1,
    M_ON    = 3'd2,
    M_OFF   = 3'd3,
    M_WALK  = 3'd4,
    M_BLINK = 3'd5
  } mode_e;
  localparam mode_e MODE_MAP [8] = '{M_ALT, M_ON, M_WALK, M_BLINK, M_OFF, M_OFF, M_OFF, M_OFF};
  localparam logic [7:0] PAT_A5 = 8'hA5;
  localparam logic [7:0] PWM_DIM_THRESH = 8'd32;
endpackage

// File: rtl/ut_debounce.sv
// ut_debounce: 2-flop synchroniser, debounce counter and press (1->0) detect for one active-low button.
module ut_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic but_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d, vld_q, vld_d;
  logic stable_q, stable_d, armed_q, armed_d, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // armed stays low until a released level is seen after reset, so a button held through reset is not a press
  always_comb begin
    sync_d = {sync_q[0], but_n};
    vld_d = {vld_q[0], 1'b1};
    diff = sync_q[1] ^ stable_q;
    done = cnt_q == CW'(DEBOUNCE_CYCLES);
    cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
    stable_d = (diff && done) ? sync_q[1] : stable_q;
    armed_d = armed_q | (vld_q[1] & sync_q[1]);
    press = armed_q & stable_q & ~stable_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      vld_q <= 2'b00;
      stable_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      vld_q <= vld_d;
      stable_q <= stable_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ut_led_pattern_gen.sv
// ut_led_pattern_gen: debounced buttons select a display mode driving static/animated LED patterns.
// Optional UT_LED_PWM_EN adds a dim input that gates the LEDs at 1/8 duty.
module ut_led_pattern_gen
  import ut_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int N_BUT = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef UT_LED_PWM_EN
  input  logic             dim,
`endif
  input  logic [N_BUT-1:0] but_n,
  output logic [N_LED-1:0] leds,
  output logic [2:0]       mode,
  output logic             press_pulse
);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  function automatic logic [N_LED-1:0] rep8(input logic [7:0] b);
    for (int k = 0; k < N_LED; k++) rep8[k] = b[k%8];
  endfunction
  localparam logic [N_LED-1:0] PAT_55 = rep8(8'h55);
  localparam logic [N_LED-1:0] PAT_AA = rep8(8'hAA);
  localparam logic [N_LED-1:0] PAT_A5W = rep8(PAT_A5);
  logic [N_BUT-1:0] press;
  mode_e mode_q, mode_d, cur, sel_mode;
  logic [N_LED-1:0] pat_q, pat_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic press_pulse_q, press_pulse_d, ent_q, ent_d, tick;
  for (genvar i = 0; i < N_BUT; i++) begin : g_but
    ut_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .but_n(but_n[i]),
      .press(press[i])
    );
  end
  always_comb begin
    sel_mode = M_IDLE;
    for (int b = N_BUT - 1; b >= 0; b--) if (press[b]) sel_mode = MODE_MAP[3'(b)];
    cur = (mode_q > M_BLINK) ? M_IDLE : mode_q;
    mode_d = !(|press) ? mode_q : (sel_mode == cur) ? M_IDLE : sel_mode;
    press_pulse_d = |press;
    ent_d = mode_d != mode_q;
    tick = cnt_q == SW'(STEP_CYCLES - 1);
    cnt_d = (ent_d || tick) ? '0 : cnt_q + 1'b1;
    // ent_q marks the first cycle in a new mode so animations load their start pattern
    pat_d = cur == M_ALT   ? PAT_AA :
            cur == M_ON    ? {N_LED{1'b1}} :
            cur == M_OFF   ? {N_LED{1'b0}} :
            cur == M_WALK  ? (ent_q ? N_LED'(1) : tick ? {pat_q[N_LED-2:0], pat_q[N_LED-1]} : pat_q) :
            cur == M_BLINK ? (ent_q ? PAT_A5W : tick ? ~pat_q : pat_q) :
            PAT_55;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_IDLE;
      pat_q <= PAT_55;
      cnt_q <= '0;
      press_pulse_q <= 1'b0;
      ent_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pat_q <= pat_d;
      cnt_q <= cnt_d;
      press_pulse_q <= press_pulse_d;
      ent_q <= ent_d;
    end
  end
`ifdef UT_LED_PWM_EN
  logic [7:0] pwm_q, pwm_d;
  always_comb pwm_d = pwm_q + 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 8'd0;
    else pwm_q <= pwm_d;
  end
  assign leds = (dim && pwm_q >= PWM_DIM_THRESH) ? '0 : pat_q;
`else
  assign leds = pat_q;
`endif
  assign mode = mode_q;
  assign press_pulse = press_pulse_q;
endmodule

// File: tb/tb_ut_led_pattern_gen.sv
// tb_ut_led_pattern_gen: directed checks of reset, press latency, bounce, walk, blink, priority and reset-held buttons.
module tb_ut_led_pattern_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] but_n = 4'hF;
  logic [7:0] leds;
  logic [2:0] mode;
  logic press_pulse;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_leds;

  ut_led_pattern_gen #(
    .N_LED(8), .N_BUT(4), .DEBOUNCE_CYCLES(4), .STEP_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .but_n      (but_n),
    .leds       (leds),
    .mode       (mode),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n, input string tag);
    int p = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (press_pulse) p++;
    end
    check(tag, p, 0);
  endtask

  // drive a press, expect a single pulse 7 cycles after the edge, return one cycle after it
  task automatic press(input logic [3:0] m, input logic [2:0] em, input logic [7:0] el, input string tag);
    int lat = 0;
    int p = 0;
    @(negedge clk);
    but_n = but_n & ~m;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (press_pulse) p++;
      if (press_pulse && lat == 0) begin
        lat = k;
        check({tag, "_mode"}, mode, em);
      end else if (lat != 0 && k == lat + 1) begin
        check({tag, "_leds"}, leds, el);
        break;
      end
    end
    check({tag, "_lat"}, lat, 7);
    check({tag, "_npulse"}, p, 1);
  endtask

  task automatic release_btn(input logic [3:0] m, input string tag);
    @(negedge clk);
    but_n = but_n | m;
    idle(10, tag);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_leds", leds, 8'h55);
    check("rst_mode", mode, 0);
    check("rst_pulse", press_pulse, 0);
    cyc(3);
    @(negedge clk) rst_n = 1'b1;
    idle(100, "idle_pulse");
    check("idle_leds", leds, 8'h55);
    check("idle_mode", mode, 0);

    press(4'b0001, 3'd1, 8'hAA, "alt");
    release_btn(4'b0001, "alt_rel");
    press(4'b0001, 3'd0, 8'h55, "back_idle");
    release_btn(4'b0001, "idle_rel");

    @(negedge clk) but_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    but_n[1] = 1'b1;
    press(4'b0010, 3'd2, 8'hFF, "bounce");
    release_btn(4'b0010, "on_rel");

    press(4'b0100, 3'd4, 8'h01, "walk");
    exp_leds = 8'h01;
    for (int j = 1; j <= 8; j++) begin
      cyc(j == 1 ? 2 : 3);
      exp_leds = {exp_leds[6:0], exp_leds[7]};
      check($sformatf("walk_step%0d", j), leds, exp_leds);
    end
    release_btn(4'b0100, "walk_rel");

    press(4'b1010, 3'd2, 8'hFF, "simul");
    release_btn(4'b1010, "simul_rel");

    press(4'b1000, 3'd5, 8'hA5, "blink");
    cyc(2);
    check("blink_1", leds, 8'h5A);
    cyc(3);
    check("blink_2", leds, 8'hA5);
    release_btn(4'b1000, "blink_rel");

    press(4'b0100, 3'd4, 8'h01, "walk2");
    cyc(4);
    #2 rst_n = 1'b0;
    but_n = 4'b1110;
    #1;
    check("midrst_leds", leds, 8'h55);
    check("midrst_mode", mode, 0);
    check("midrst_pulse", press_pulse, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20, "held_nopress");
    check("held_mode", mode, 0);
    check("held_leds", leds, 8'h55);
    release_btn(4'b0001, "held_rel");
    press(4'b0001, 3'd1, 8'hAA, "repress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
